// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour constants, blanking code, scheduler states
// and default active-area size.
package vga_pkg;

  localparam logic [15:0] BLACK     = 16'h0000;
  localparam logic [15:0] WHITE     = 16'hFFFF;
  localparam logic [9:0]  PIX_BLANK = 10'h3ff;
  localparam int          H_ACT_DEF = 640;
  localparam int          V_ACT_DEF = 480;

  typedef enum logic [1:0] {
    SHOW = 2'd0,
    PEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/vga_pix_mux.sv
// Pixel path: NUM_PAT:1 source mux, forced black on blanking or when the
// scheduler asks for it, then one output register (1-clk latency).
module vga_pix_mux
  import vga_pkg::*;
#(
  parameter int NUM_PAT = 4,
  parameter int DW      = 16,
  parameter int SW      = $clog2(NUM_PAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [NUM_PAT*DW-1:0] pat_data,
  input  logic [SW-1:0]         sel,
  input  logic                  force_zero,
  output logic [DW-1:0]         pix_data
);

  logic [DW-1:0] src_p0;
  logic          blank_p0;
  logic [DW-1:0] pix_p1;

  // pick the currently selected source for this pixel
  always_comb begin
    src_p0 = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (sel == SW'(i)) src_p0 = pat_data[i*DW +: DW];
    end
  end

  assign blank_p0 = (pix_x == PIX_BLANK) || (pix_y == PIX_BLANK) || force_zero;

  // stage p0 -> p1: register the (possibly blanked) pixel
  always_ff @(posedge clk) begin
    if (rst) pix_p1 <= '0;
    else     pix_p1 <= blank_p0 ? DW'(BLACK) : src_p0;
  end

  assign pix_data = pix_p1;

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous selector between NUM_PAT pattern generators. Requests
// from key pulses or the auto-dwell timer accumulate in a target index and
// are committed only on the last active pixel of a frame, so frames never tear.
// Optional macro VGA_PATTERN_GAP_EN: every commit is followed by one all-black
// frame before the new source becomes visible.
module vga_pattern_scheduler
  import vga_pkg::*;
#(
  parameter  int NUM_PAT      = 4,
  parameter  int DW           = 16,
  parameter  int H_ACT        = H_ACT_DEF,
  parameter  int V_ACT        = V_ACT_DEF,
  parameter  int DWELL_FRAMES = 60,
  localparam int SW           = $clog2(NUM_PAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [NUM_PAT*DW-1:0] pat_data,
  input  logic                  key_next,
  input  logic                  key_prev,
  input  logic                  auto_en,
  output logic [DW-1:0]         pix_data,
  output logic [SW-1:0]         pat_sel,
  output logic                  sw_pulse
);

  localparam int            DCW        = $clog2(DWELL_FRAMES + 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_PAT - 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_FRAMES - 1);
`ifdef VGA_PATTERN_GAP_EN
  localparam sched_state_t  COMMIT_ST  = GAP;
`else
  localparam sched_state_t  COMMIT_ST  = SHOW;
`endif

  function automatic logic [SW-1:0] sel_inc(input logic [SW-1:0] s);
    return (s == SEL_LAST) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SW-1:0] sel_dec(input logic [SW-1:0] s);
    return (s == '0) ? SEL_LAST : s - 1'b1;
  endfunction

  sched_state_t   state, state_nxt;
  logic [SW-1:0]  target, target_nxt, sel_nxt, tgt_req, tgt_commit;
  logic           pending, pending_nxt, pend_req, sw_nxt;
  logic [DCW-1:0] dwell_cnt, dwell_nxt;
  logic           bnd, in_gap, auto_fire, commit, force_zero;

  assign bnd    = (pix_x == 10'(H_ACT - 1)) && (pix_y == 10'(V_ACT - 1));
  assign in_gap = (state == GAP);

  // state and scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SHOW;
      target    <= '0;
      pending   <= 1'b0;
      dwell_cnt <= '0;
      pat_sel   <= '0;
      sw_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      pending   <= pending_nxt;
      dwell_cnt <= dwell_nxt;
      pat_sel   <= sel_nxt;
      sw_pulse  <= sw_nxt;
    end
  end

  // next-state: apply this cycle's key first, then decide a commit at bnd
  always_comb begin
    tgt_req = target;
    if (key_next && !key_prev)      tgt_req = sel_inc(target);
    else if (key_prev && !key_next) tgt_req = sel_dec(target);
    pend_req   = pending || (key_next ^ key_prev);
    auto_fire  = bnd && auto_en && !in_gap && !pend_req && (dwell_cnt == DWELL_LAST);
    commit     = bnd && (pend_req || auto_fire);
    tgt_commit = auto_fire ? sel_inc(pat_sel) : tgt_req;

    target_nxt  = tgt_req;
    pending_nxt = pend_req;
    sel_nxt     = pat_sel;
    sw_nxt      = 1'b0;
    if (!auto_en)             dwell_nxt = '0;
    else if (bnd && !in_gap)  dwell_nxt = dwell_cnt + 1'b1;
    else                      dwell_nxt = dwell_cnt;

    if (commit) begin
      target_nxt  = tgt_commit;
      pending_nxt = 1'b0;
      dwell_nxt   = '0;
      sel_nxt     = tgt_commit;
      sw_nxt      = (tgt_commit != pat_sel);
    end

    state_nxt = state;
    case (state)
      SHOW, PEND: state_nxt = commit ? COMMIT_ST : (pend_req ? PEND : SHOW);
      GAP:        if (bnd) state_nxt = commit ? GAP : SHOW;
      default:    state_nxt = SHOW;
    endcase
  end

  // outputs decoded from state: black frame while in GAP
  always_comb begin
`ifdef VGA_PATTERN_GAP_EN
    force_zero = in_gap;
`else
    force_zero = 1'b0;
`endif
  end

  vga_pix_mux #(
    .NUM_PAT (NUM_PAT),
    .DW      (DW),
    .SW      (SW)
  ) u_pix_mux (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pat_data   (pat_data),
    .sel        (pat_sel),
    .force_zero (force_zero),
    .pix_data   (pix_data)
  );

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler on a reduced raster (8x4 active,
// 10x6 total) so every frame boundary is cheap to reach.
module tb_vga_pattern_scheduler;
  import vga_pkg::*;

  localparam int NP = 4, DWB = 16, HA = 8, VA = 4, HT = 10, VT = 6, DWELL = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        pix_x, pix_y;
  logic [NP*DWB-1:0] pat_data;
  logic              key_next, key_prev, auto_en;
  logic [DWB-1:0]    pix_data;
  logic [1:0]        pat_sel;
  logic              sw_pulse;

  int         hc, vc;
  logic [9:0] prev_x, prev_y;
  int         n_chk = 0, n_bad = 0;

  vga_pattern_scheduler #(
    .NUM_PAT(NP), .DW(DWB), .H_ACT(HA), .V_ACT(VA), .DWELL_FRAMES(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pat_data(pat_data),
    .key_next(key_next), .key_prev(key_prev), .auto_en(auto_en),
    .pix_data(pix_data), .pat_sel(pat_sel), .sw_pulse(sw_pulse)
  );

  always #5 clk = ~clk;

  // source s at active (x,y) = {s+1, y[5:0], x[5:0]}; blanking gives 0
  function automatic logic [15:0] exp_pix(input int sel, input logic [9:0] x, input logic [9:0] y);
    if (x == 10'h3ff || y == 10'h3ff) return 16'h0000;
    return {4'(sel + 1), y[5:0], x[5:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    pix_x = (vc < VA && hc < HA) ? 10'(hc) : 10'h3ff;
    pix_y = (vc < VA) ? 10'(vc) : 10'h3ff;
    for (int i = 0; i < NP; i++)
      pat_data[i*DWB +: DWB] = (pix_x == 10'h3ff || pix_y == 10'h3ff) ? WHITE
                               : {4'(i + 1), pix_y[5:0], pix_x[5:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    prev_x = pix_x;
    prev_y = pix_y;
    key_next = 1'b0;
    key_prev = 1'b0;
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc++;
      if (vc == VT) vc = 0;
    end
    drive();
  endtask

  task automatic goto(input int x, input int y);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (hc == x && vc == y) return;
      tick();
    end
    chk("goto_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_bnd();
    goto(HA - 1, VA - 1);
    tick();
  endtask

  task automatic press(input logic n, input logic p);
    key_next = n;
    key_prev = p;
    tick();
  endtask

  task automatic check_frame(input int sel, input logic zero);
    goto(0, 0);
    repeat (HT * VT) begin
      tick();
      chk("frame_pix", 32'(pix_data), zero ? 32'd0 : 32'(exp_pix(sel, prev_x, prev_y)));
    end
  endtask

  initial begin
    rst = 1'b1; key_next = 1'b0; key_prev = 1'b0; auto_en = 1'b0;
    hc = 3; vc = 1; drive();
    tick(); tick();
    chk("rst_pix", 32'(pix_data), 32'd0);
    chk("rst_sel", 32'(pat_sel), 32'd0);
    chk("rst_sw", 32'(sw_pulse), 32'd0);
    rst = 1'b0;
    goto(0, 0); tick();
    chk("first_pix", 32'(pix_data), 32'h1000);

`ifndef VGA_PATTERN_GAP_EN
    // manual next: held until the frame boundary
    goto(3, 1); press(1'b1, 1'b0);
    chk("t2_hold", 32'(pat_sel), 32'd0);
    goto(HA - 1, VA - 1);
    chk("t2_prebnd_sel", 32'(pat_sel), 32'd0);
    chk("t2_prebnd_sw", 32'(sw_pulse), 32'd0);
    tick();
    chk("t2_bnd_pix", 32'(pix_data), 32'(exp_pix(0, 10'(HA - 1), 10'(VA - 1))));
    chk("t2_sel", 32'(pat_sel), 32'd1);
    chk("t2_sw", 32'(sw_pulse), 32'd1);
    tick();
    chk("t2_blank_pix", 32'(pix_data), 32'd0);
    chk("t2_sw_end", 32'(sw_pulse), 32'd0);
    check_frame(1, 1'b0);

    // accumulate and wrap; simultaneous keys ignored
    goto(2, 0); press(1'b1, 1'b0); next_bnd();
    chk("t3_sel2", 32'(pat_sel), 32'd2);
    goto(1, 0); press(1'b1, 1'b0); press(1'b1, 1'b0);
    goto(5, 1); press(1'b1, 1'b0); next_bnd();
    chk("t3_wrap_sel", 32'(pat_sel), 32'd1);
    chk("t3_wrap_sw", 32'(sw_pulse), 32'd1);
    goto(2, 0); press(1'b1, 1'b1); next_bnd();
    chk("t3_both_sel", 32'(pat_sel), 32'd1);
    chk("t3_both_sw", 32'(sw_pulse), 32'd0);

    // reset mid-frame discards a pending request
    goto(4, 0); press(1'b0, 1'b1);
    goto(4, 2); rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_sel", 32'(pat_sel), 32'd0);
    chk("rst_mid_pix", 32'(pix_data), 32'd0);
    next_bnd();
    chk("rst_discard", 32'(pat_sel), 32'd0);
    chk("rst_discard_sw", 32'(sw_pulse), 32'd0);

    // auto advance every DWELL frames: 0,1,2,3,0
    auto_en = 1'b1;
    for (int k = 1; k <= 4 * DWELL; k++) begin
      next_bnd();
      chk("t4_sel", 32'(pat_sel), 32'((k / DWELL) % NP));
      chk("t4_sw", 32'(sw_pulse), (k % DWELL == 0) ? 32'd1 : 32'd0);
    end
    // a manual commit restarts the dwell count
    next_bnd();
    chk("t4_dwell1", 32'(pat_sel), 32'd0);
    goto(2, 0); press(1'b1, 1'b0); next_bnd();
    chk("t4_key_sel", 32'(pat_sel), 32'd1);
    next_bnd(); chk("t4_hold_a", 32'(pat_sel), 32'd1);
    next_bnd(); chk("t4_hold_b", 32'(pat_sel), 32'd1);
    next_bnd(); chk("t4_auto_after_key", 32'(pat_sel), 32'd2);
    auto_en = 1'b0;

    // key on the exact boundary cycle commits there
    goto(HA - 1, VA - 1); press(1'b1, 1'b0);
    chk("t5_bnd_pix", 32'(pix_data), 32'(exp_pix(2, 10'(HA - 1), 10'(VA - 1))));
    chk("t5_bnd_sel", 32'(pat_sel), 32'd3);
    chk("t5_bnd_sw", 32'(sw_pulse), 32'd1);
    // next then prev: committed with no change
    goto(1, 0); press(1'b1, 1'b0); press(1'b0, 1'b1); next_bnd();
    chk("t5_np_sel", 32'(pat_sel), 32'd3);
    chk("t5_np_sw", 32'(sw_pulse), 32'd0);
    check_frame(3, 1'b0);
    // prev x3 from 3 wraps through 0 to 0? 3-3 = 0
    goto(1, 0); press(1'b0, 1'b1); press(1'b0, 1'b1); press(1'b0, 1'b1); next_bnd();
    chk("t5_prev3_sel", 32'(pat_sel), 32'd0);
    goto(1, 0); press(1'b0, 1'b1); next_bnd();
    chk("t5_prev_wrap", 32'(pat_sel), 32'd3);
    chk("t5_prev_sw", 32'(sw_pulse), 32'd1);
`else
    // gap frame after each commit
    goto(2, 0); press(1'b1, 1'b0); next_bnd();
    chk("t6_sel1", 32'(pat_sel), 32'd1);
    chk("t6_sw1", 32'(sw_pulse), 32'd1);
    check_frame(1, 1'b1);
    check_frame(1, 1'b0);
    // request during the gap frame commits at its exit boundary
    goto(2, 0); press(1'b1, 1'b0); next_bnd();
    chk("t6_sel2", 32'(pat_sel), 32'd2);
    goto(2, 0); press(1'b1, 1'b0); next_bnd();
    chk("t6_sel3", 32'(pat_sel), 32'd3);
    chk("t6_sw3", 32'(sw_pulse), 32'd1);
    check_frame(3, 1'b1);
    check_frame(3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
